gelato_fetch_scheduler: RTL
===========================

GELATO_FETCH_SCHEDULER -- requirements
Module: gelato_fetch_scheduler

Interface
REQ-001 Parameter: WARP_NUM, 4, number of warps; power of two, >=2.
REQ-002 Parameter: PC_WIDTH, 32, PC width in bits.
REQ-003 Parameter: SPLIT_W, 4, split-table-number width; WID_W = clog2(WARP_NUM).
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: rdy  in  1  global enable; when low all registers hold.
REQ-007 Port: pc_valid  in  WARP_NUM  per-warp PC-table entry valid.
REQ-008 Port: pc  in  WARP_NUM*PC_WIDTH  per-warp PC, warp i at bits [i*PC_WIDTH +: PC_WIDTH].
REQ-009 Port: pc_split_num  in  WARP_NUM*SPLIT_W  per-warp split-table number, same packing.
REQ-010 Port: done_valid  in  1  an issued warp's instruction resolved in decode/split update.
REQ-011 Port: done_warp  in  WID_W  warp index for done_valid.
REQ-012 Port: fetch_valid  out  1  fetch request valid.
REQ-013 Port: fetch_ready  in  1  fetch unit accepts request.
REQ-014 Port: fetch_warp  out  WID_W  selected warp.
REQ-015 Port: fetch_pc  out  PC_WIDTH  PC of selected warp.
REQ-016 Port: fetch_split_num  out  SPLIT_W  split-table number of selected warp.

Function
REQ-017 Scheduler SHALL keep a busy mask (one bit per warp); eligible = pc_valid & ~busy, using the registered busy value.
REQ-018 FSM SHALL have states IDLE (fetch_valid=0) and ISSUE (fetch_valid=1).
REQ-019 IDLE: when rdy=1 and eligible!=0, the first eligible warp at or after rr_ptr (circular) SHALL be selected; warp, PC and split number are latched into the output registers; busy[sel] is set; next state ISSUE. fetch_valid SHALL rise one cycle after eligibility is seen.
REQ-020 ISSUE: fetch_warp/pc/split_num SHALL hold stable until a handshake (fetch_valid & fetch_ready & rdy).
REQ-021 On handshake: rr_ptr = (fetch_warp+1) mod WARP_NUM. A new selection SHALL be made in the same cycle with fetch_warp excluded, starting at the new rr_ptr. If one exists, its values are loaded and the FSM stays in ISSUE (back-to-back, no bubble). Otherwise the FSM goes to IDLE.
REQ-022 done_valid=1 with rdy=1 SHALL clear busy[done_warp] at the next edge; the cleared warp becomes eligible one cycle later.
REQ-023 done_valid for a non-busy warp SHALL have no effect.
REQ-024 Same-cycle set and clear of the same busy bit: set wins.
REQ-025 If pc_valid[sel] drops while ISSUE is pending, the request SHALL still be held until the handshake (no retraction).
REQ-026 rdy=0 SHALL freeze FSM, busy, rr_ptr and outputs; fetch_ready and done_valid are ignored that cycle.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, fetch_valid 0, fetch_warp 0, fetch_pc 0, fetch_split_num 0, busy all 0, rr_ptr 0, and perf counters 0 if present.
REQ-028 Reset mid-ISSUE SHALL drop the pending request without a handshake.

Configuration
REQ-029 Macro GELATO_FETCH_SKD_PERF_EN, when defined, SHALL add two 32-bit output ports:
 - perf_issue_cnt: +1 per handshake.
 - perf_stall_cnt: +1 per rdy-high cycle with fetch_valid & ~fetch_ready.
 Both wrap modulo 2^32.
REQ-030 Without GELATO_FETCH_SKD_PERF_EN these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Round-robin: WARP_NUM=4, pc_valid=4'b1111, fetch_ready=1, done_valid pulsed for each warp one cycle after its issue -> issue order 0,1,2,3,0, back-to-back with no bubble.
REQ-032 Backpressure: warp 2 only valid, pc[2]=0x100, fetch_ready=0 for 5 cycles then 1 -> fetch_valid high 6 cycles with pc 0x100 stable; one handshake; perf_stall_cnt=5 and perf_issue_cnt=1 when the macro is defined.
REQ-033 Busy blocking: warp 1 issued and no done -> warp 1 never reissued. done_warp=1 pulse -> warp 1 reissued two cycles later.
REQ-034 rdy freeze: rdy=0 during ISSUE with fetch_ready=1 -> no handshake and outputs unchanged; rdy=1 -> handshake in that cycle.
REQ-035 Async reset: assert rst mid-cycle during ISSUE -> fetch_valid=0 before the next edge; busy cleared; after release with pc_valid=4'b1000, warp 3 is issued (rr_ptr=0, first eligible).

Source files
------------

// File: rtl/gelato_fetch_scheduler.sv
// Round-robin warp fetch scheduler: picks an eligible (valid, not busy) warp and holds the request until fetch accepts it.
// Optional perf counters are enabled with GELATO_FETCH_SKD_PERF_EN.
module gelato_fetch_scheduler #(
    parameter int unsigned WARP_NUM = 4,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned SPLIT_W  = 4,
    localparam int unsigned WID_W   = $clog2(WARP_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [WARP_NUM-1:0]           pc_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]  pc,
    input  logic [WARP_NUM*SPLIT_W-1:0]   pc_split_num,
    input  logic                          done_valid,
    input  logic [WID_W-1:0]              done_warp,
    output logic                          fetch_valid,
    input  logic                          fetch_ready,
    output logic [WID_W-1:0]              fetch_warp,
    output logic [PC_WIDTH-1:0]           fetch_pc,
    output logic [SPLIT_W-1:0]            fetch_split_num
`ifdef GELATO_FETCH_SKD_PERF_EN
    ,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [WARP_NUM-1:0]  busy, busy_nxt, eligible, sel_mask;
    logic [WID_W-1:0]     rr_ptr, rr_ptr_nxt, sel_ptr, sel_idx, cand, warp_nxt;
    logic [PC_WIDTH-1:0]  pc_nxt;
    logic [SPLIT_W-1:0]   split_nxt;
    logic                 sel_found, load;

    assign fetch_valid = (state == ISSUE);
    assign eligible    = pc_valid & ~busy;

    // Circular priority search; after a handshake it restarts past the accepted warp and skips it.
    always_comb begin
        sel_ptr   = rr_ptr;
        sel_mask  = eligible;
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        if (state == ISSUE) begin
            sel_ptr            = fetch_warp + WID_W'(1);
            sel_mask[fetch_warp] = 1'b0;
        end
        for (int i = 0; i < int'(WARP_NUM); i++) begin
            cand = sel_ptr + WID_W'(i);
            if (!sel_found && sel_mask[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state, busy and output-register update; everything holds while rdy is low.
    always_comb begin
        state_nxt  = state;
        busy_nxt   = busy;
        rr_ptr_nxt = rr_ptr;
        warp_nxt   = fetch_warp;
        pc_nxt     = fetch_pc;
        split_nxt  = fetch_split_num;
        load       = 1'b0;
        if (rdy) begin
            if (done_valid) begin
                busy_nxt[done_warp] = 1'b0;
            end
            case (state)
                IDLE: begin
                    load = sel_found;
                end
                ISSUE: begin
                    if (fetch_ready) begin
                        rr_ptr_nxt = fetch_warp + WID_W'(1);
                        load       = sel_found;
                        if (!sel_found) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // Set after clear so a same-cycle set wins.
            if (load) begin
                state_nxt         = ISSUE;
                warp_nxt          = sel_idx;
                pc_nxt            = pc[32'(sel_idx) * PC_WIDTH +: PC_WIDTH];
                split_nxt         = pc_split_num[32'(sel_idx) * SPLIT_W +: SPLIT_W];
                busy_nxt[sel_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= '0;
            rr_ptr          <= '0;
            fetch_warp      <= '0;
            fetch_pc        <= '0;
            fetch_split_num <= '0;
        end else begin
            state           <= state_nxt;
            busy            <= busy_nxt;
            rr_ptr          <= rr_ptr_nxt;
            fetch_warp      <= warp_nxt;
            fetch_pc        <= pc_nxt;
            fetch_split_num <= split_nxt;
        end
    end

`ifdef GELATO_FETCH_SKD_PERF_EN
    // Handshake and backpressure counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (rdy) begin
            if (fetch_valid && fetch_ready) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (fetch_valid && !fetch_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule
